// File: rtl/weight_load_sched.sv
// weight_load_sched
// Streams weight tiles from the weight buffer into the systolic array's
// shadow registers and hands each tile over with a one-cycle swap pulse.
// Tile k+1 is loaded while the array is still computing on tile k; the
// swap for k+1 is held back until the array reports compute_done for k.

module weight_load_sched #(
    parameter int SYS_ROWS = 4,
    parameter int SYS_COLS = 4,
    parameter int TILE_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              compute_done,
    output logic              read,
    output logic              swap,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              done
);

    localparam int RW = $clog2(SYS_ROWS + 1);
    localparam int CW = $clog2(SYS_COLS + 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SYS_ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(SYS_COLS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        SWAP_WAIT,
        FINISH
    } state_t;

    state_t            state;
    logic [RW-1:0]     row_cnt;
    logic [CW-1:0]     drain_cnt;
    logic [TILE_W-1:0] count_q;
    logic              free;

    logic cd_eff;
    logic free_eff;
    logic last_tile;
    logic drain_end;
    logic swap_ok;

    // A compute_done seen while our swap pulse is on the wire cannot belong to
    // the tile being handed over, so it is dropped. Otherwise it marks the array
    // free this cycle, letting a waiting swap or done go out on the next edge.
    assign cd_eff    = compute_done & ~swap;
    assign free_eff  = free | cd_eff;
    assign last_tile = (tile_idx == count_q - TILE_W'(1));
    assign drain_end = (state == DRAIN) && (drain_cnt == COL_LAST);
    assign swap_ok   = ((state == SWAP_WAIT) || drain_end) && free_eff;

    // Main sequencer: state, counters, free flag and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            drain_cnt <= '0;
            count_q   <= '0;
            free      <= 1'b0;
            read      <= 1'b0;
            swap      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            tile_idx  <= '0;
        end else begin
            read <= 1'b0;
            swap <= 1'b0;
            done <= 1'b0;
            free <= free_eff;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_tiles != '0) begin
                            state    <= LOAD;
                            count_q  <= num_tiles;
                            tile_idx <= '0;
                            free     <= 1'b1;
                            busy     <= 1'b1;
                            read     <= 1'b1;
                            row_cnt  <= RW'(1);
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (row_cnt == ROW_LAST) begin
                        state     <= DRAIN;
                        row_cnt   <= '0;
                        drain_cnt <= CW'(1);
                    end else begin
                        read    <= 1'b1;
                        row_cnt <= row_cnt + RW'(1);
                    end
                end

                DRAIN: begin
                    if (drain_cnt == COL_LAST) begin
                        drain_cnt <= '0;
                        state     <= SWAP_WAIT;
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end

                SWAP_WAIT: begin
                    state <= SWAP_WAIT;
                end

                FINISH: begin
                    if (free_eff) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // The hand-over is shared by the end of drain and the wait state;
            // the swap consumes the free flag even if compute_done also arrived.
            if (swap_ok) begin
                swap <= 1'b1;
                free <= 1'b0;
                if (last_tile) begin
                    state <= FINISH;
                end else begin
                    tile_idx <= tile_idx + TILE_W'(1);
                    row_cnt  <= '0;
                    state    <= LOAD;
                end
            end
        end
    end

endmodule
